// File: rtl/imem_boot_loader.sv
// UART byte stream -> little-endian 32-bit words on the instruction-RAM write port,
// holding the core in reset while loading. IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_boot_loader #(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned MAX_WORDS      = 1024,
  parameter logic [7:0]  MAGIC          = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_hold,
  output logic                  done,
  output logic                  error,
  output logic [10:0]           words_written
);

  localparam int unsigned GAP_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    MAGIC_S,
    LEN_LO,
    LEN_HI,
    DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE,
    ERROR
  } state_e;

  state_e                state_q, state_d;
  logic                  imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]           imem_wdata_q, imem_wdata_d;
  logic                  core_hold_q, core_hold_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [10:0]           words_written_q, words_written_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [31:0]           word_q, word_d;
  logic [15:0]           len_q, len_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            xor_q, xor_d;
`endif
  logic                  fail, finish;
  logic [15:0]           len_full;

  // The loader never back-pressures the UART; stray bytes outside a load are dropped.
  assign rx_ready      = 1'b1;
  assign imem_we       = imem_we_q;
  assign imem_addr     = imem_addr_q;
  assign imem_wdata    = imem_wdata_q;
  assign core_hold     = core_hold_q;
  assign done          = done_q;
  assign error         = error_q;
  assign words_written = words_written_q;
  assign len_full      = {rx_data, len_q[7:0]};

  always_comb begin
    state_d         = state_q;
    imem_we_d       = 1'b0;
    imem_addr_d     = imem_addr_q;
    imem_wdata_d    = imem_wdata_q;
    core_hold_d     = core_hold_q;
    done_d          = done_q;
    error_d         = error_q;
    words_written_d = words_written_q;
    byte_cnt_d      = byte_cnt_q;
    word_d          = word_q;
    len_d           = len_q;
    gap_d           = gap_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    xor_d           = xor_q;
`endif
    fail            = 1'b0;
    finish          = 1'b0;

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d         = MAGIC_S;
          core_hold_d     = 1'b1;
          done_d          = 1'b0;
          error_d         = 1'b0;
          words_written_d = '0;
          byte_cnt_d      = '0;
          gap_d           = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d           = '0;
`endif
        end
      end
      default: begin
        if (rx_valid) begin
          gap_d = '0;
          case (state_q)
            MAGIC_S: begin
              if (rx_data == MAGIC) state_d = LEN_LO;
              else                  fail    = 1'b1;
            end
            LEN_LO: begin
              len_d   = {8'h00, rx_data};
              state_d = LEN_HI;
            end
            LEN_HI: begin
              len_d = len_full;
              if (len_full == 16'd0 || 32'(len_full) > MAX_WORDS) fail = 1'b1;
              else                                                  state_d = DATA;
            end
            DATA: begin
              word_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
              byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
              xor_d = xor_q ^ rx_data;
`endif
              // Fourth byte completes the word; the write strobe appears next cycle.
              if (byte_cnt_q == 2'd3) begin
                imem_we_d       = 1'b1;
                imem_addr_d     = ADDR_WIDTH'({words_written_q, 2'b00});
                imem_wdata_d    = {rx_data, word_q[23:0]};
                words_written_d = words_written_q + 11'd1;
                if ((16'(words_written_q) + 16'd1) == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state_d = CHECK;
`else
                  finish  = 1'b1;
`endif
                end
              end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
              if (rx_data == xor_q) finish = 1'b1;
              else                  fail   = 1'b1;
            end
`endif
            default: ;
          endcase
        end else if (gap_q == GAP_W'(TIMEOUT_CYCLES - 1)) begin
          fail = 1'b1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
    endcase

    if (fail) begin
      state_d     = ERROR;
      core_hold_d = 1'b0;
      error_d     = 1'b1;
    end
    if (finish) begin
      state_d     = DONE;
      core_hold_d = 1'b0;
      done_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      imem_we_q       <= 1'b0;
      imem_addr_q     <= '0;
      imem_wdata_q    <= '0;
      core_hold_q     <= 1'b0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
      words_written_q <= '0;
      byte_cnt_q      <= '0;
      word_q          <= '0;
      len_q           <= '0;
      gap_q           <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q           <= '0;
`endif
    end else begin
      state_q         <= state_d;
      imem_we_q       <= imem_we_d;
      imem_addr_q     <= imem_addr_d;
      imem_wdata_q    <= imem_wdata_d;
      core_hold_q     <= core_hold_d;
      done_q          <= done_d;
      error_q         <= error_d;
      words_written_q <= words_written_d;
      byte_cnt_q      <= byte_cnt_d;
      word_q          <= word_d;
      len_q           <= len_d;
      gap_q           <= gap_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q           <= xor_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader with a short timeout (16 cycles); every imem write is logged.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [11:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_hold;
  logic        done;
  logic        error;
  logic [10:0] words_written;

  int checks   = 0;
  int failures = 0;
  int wr_n     = 0;
  int base;
  logic [11:0] wa [0:63];
  logic [31:0] wd [0:63];
  logic [7:0]  img [0:10];

  imem_boot_loader #(
    .ADDR_WIDTH(12), .MAX_WORDS(1024), .MAGIC(8'hA5), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_hold(core_hold), .done(done), .error(error), .words_written(words_written)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we && wr_n < 64) begin
      wa[wr_n] = imem_addr;
      wd[wr_n] = imem_wdata;
      wr_n++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_image(input logic [7:0] ck);
    for (int i = 0; i < 11; i++) send(img[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(ck);
`else
    if (ck == 8'hxx) ; // checksum byte only exists in the checksum build
`endif
  endtask

  task automatic check_good_load(input string tag, input int b);
    idle(1);
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_error"}, 32'(error), 0);
    chk({tag, "_words"}, 32'(words_written), 2);
    chk({tag, "_hold"}, 32'(core_hold), 0);
    chk({tag, "_nwr"}, 32'(wr_n), 32'(b + 2));
    chk({tag, "_a0"}, 32'(wa[b]), 32'h000);
    chk({tag, "_d0"}, wd[b], 32'h0000_0013);
    chk({tag, "_a1"}, 32'(wa[b+1]), 32'h004);
    chk({tag, "_d1"}, wd[b+1], 32'hFF9F_F06F);
  endtask

  initial begin
    img = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'hF0, 8'h9F, 8'hFF};
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    idle(2);
    chk("rst_we", 32'(imem_we), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_hold", 32'(core_hold), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_words", 32'(words_written), 0);
    chk("rx_ready", 32'(rx_ready), 1);
    reset = 1'b0;
    idle(1);

    // Test 1: valid two-word image (data XOR = 0xEC)
    pulse_start();
    chk("t1_hold_start", 32'(core_hold), 1);
    for (int i = 0; i < 11; i++) begin
      send(img[i]);
      if (i == 6) begin
        chk("t1_we_word0", 32'(imem_we), 1);
        chk("t1_hold_mid", 32'(core_hold), 1);
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("t1_done_before_ck", 32'(done), 0);
    send(8'hEC);
    chk("t1_done_after_ck", 32'(done), 1);
`else
    chk("t1_done_last_byte", 32'(done), 1);
    chk("t1_we_word1", 32'(imem_we), 1);
`endif
    check_good_load("t1", 0);
    send(8'h77);
    idle(1);
    chk("t1_post_done", 32'(done), 1);
    chk("t1_post_nwr", 32'(wr_n), 2);

    // Test 2: bad magic, then reload
    base = wr_n;
    pulse_start();
    chk("t2_done_clr", 32'(done), 0);
    send(8'h5A);
    chk("t2_error", 32'(error), 1);
    chk("t2_hold", 32'(core_hold), 0);
    idle(2);
    chk("t2_nwr", 32'(wr_n), 32'(base));
    pulse_start();
    chk("t2_err_clr", 32'(error), 0);
    send_image(8'hEC);
    check_good_load("t2", base);

    // Test 3: length bounds
    pulse_start();
    send(8'hA5); send(8'h01);
    chk("t3_pre", 32'(error), 0);
    send(8'h04);
    chk("t3_n1025", 32'(error), 1);
    pulse_start();
    send(8'hA5); send(8'h00); send(8'h00);
    chk("t3_n0", 32'(error), 1);
    pulse_start();
    send(8'hA5); send(8'h00); send(8'h04);
    chk("t3_n1024_ok", 32'(error), 0);
    idle(16);
    chk("t3_n1024_to", 32'(error), 1);

    // Test 4: timeout on the 16th idle cycle
    pulse_start();
    send(8'hA5); send(8'h02);
    idle(15);
    chk("t4_err_15", 32'(error), 0);
    chk("t4_hold_15", 32'(core_hold), 1);
    idle(1);
    chk("t4_err_16", 32'(error), 1);
    chk("t4_hold_16", 32'(core_hold), 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Test 5: wrong checksum keeps written words
    base = wr_n;
    pulse_start();
    send_image(8'h00);
    idle(1);
    chk("t5_error", 32'(error), 1);
    chk("t5_done", 32'(done), 0);
    chk("t5_words", 32'(words_written), 2);
    chk("t5_nwr", 32'(wr_n), 32'(base + 2));
    chk("t5_d1", wd[base+1], 32'hFF9F_F06F);
`endif

    // Test 6: reset after five data bytes
    base = wr_n;
    pulse_start();
    for (int i = 0; i < 8; i++) send(img[i]);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_we", 32'(imem_we), 0);
    chk("t6_addr", 32'(imem_addr), 0);
    chk("t6_wdata", imem_wdata, 0);
    chk("t6_hold", 32'(core_hold), 0);
    chk("t6_done", 32'(done), 0);
    chk("t6_error", 32'(error), 0);
    chk("t6_words", 32'(words_written), 0);
    chk("t6_nwr", 32'(wr_n), 32'(base + 1));
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1);
    pulse_start();
    send_image(8'hEC);
    check_good_load("t6", base + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
